// File: rtl/voq_linked.sv
// Shared-buffer virtual output queue: one data RAM shared by QUEUE_NUB linked-list queues,
// with a fresh-address counter plus a recycle FIFO for cell allocation.
module voq_linked #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 128,
  parameter int QUEUE_NUB   = 4,
  parameter int QUEUE_LIMIT = DEPTH,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int QW         = $clog2(QUEUE_NUB)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [QW-1:0]              wr_client,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_ready,
  input  logic                       rd_en,
  input  logic [QW-1:0]              rd_client,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic [QUEUE_NUB-1:0]       q_empty,
  output logic [QUEUE_NUB*CNT_W-1:0] q_count,
  output logic [CNT_W-1:0]           free_count,
  output logic                       err_wr_drop,
  output logic                       err_rd_empty
);

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LIMIT_C     = CNT_W'(QUEUE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE_C   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO_C = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(DEPTH - 1);

  // Recycle FIFO pointer advance with explicit wrap so non-power-of-two DEPTH works.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if (p == LAST_ADDR_C) begin
      return ADDR_ZERO_C;
    end else begin
      return p + ADDR_W'(1);
    end
  endfunction

  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [ADDR_W-1:0]     next_mem_r [DEPTH];
  logic [ADDR_W-1:0]     rec_mem_r  [DEPTH];
  logic [ADDR_W-1:0]     head_r     [QUEUE_NUB];
  logic [ADDR_W-1:0]     tail_r     [QUEUE_NUB];
  logic [CNT_W-1:0]      cnt_r      [QUEUE_NUB];
  logic [CNT_W-1:0]      free_cnt_r;
  logic [CNT_W-1:0]      fresh_ptr_r;
  logic [ADDR_W-1:0]     rec_wptr_r;
  logic [ADDR_W-1:0]     rec_rptr_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;
  logic                  err_wr_drop_r;
  logic                  err_rd_empty_r;

  logic                  wr_ready_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  use_fresh_s;
  logic [ADDR_W-1:0]     alloc_addr_s;
  logic [ADDR_W-1:0]     rd_head_s;
  logic [ADDR_W-1:0]     wr_tail_s;
  logic [QUEUE_NUB-1:0]  wr_hit_s;
  logic [QUEUE_NUB-1:0]  rd_hit_s;

  // Accept decisions and allocation address, all from registered (pre-cycle) state.
  always_comb begin
    use_fresh_s = (fresh_ptr_r != DEPTH_C);
    if (use_fresh_s) begin
      alloc_addr_s = fresh_ptr_r[ADDR_W-1:0];
    end else begin
      alloc_addr_s = rec_mem_r[rec_rptr_r];
    end
    wr_ready_s = !rst && (free_cnt_r != CNT_ZERO_C) && (cnt_r[wr_client] < LIMIT_C);
    wr_acc_s   = wr_en && wr_ready_s;
    rd_acc_s   = !rst && rd_en && (cnt_r[rd_client] != CNT_ZERO_C);
    rd_head_s  = head_r[rd_client];
    wr_tail_s  = tail_r[wr_client];
    for (int i = 0; i < QUEUE_NUB; i++) begin
      wr_hit_s[i] = wr_acc_s && (wr_client == QW'(i));
      rd_hit_s[i] = rd_acc_s && (rd_client == QW'(i));
    end
  end

  // Cell data, link pointers and recycle FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      data_mem_r[alloc_addr_s] <= wr_data;
      if (cnt_r[wr_client] != CNT_ZERO_C) begin
        next_mem_r[wr_tail_s] <= alloc_addr_s;
      end
    end
    if (rd_acc_s) begin
      rec_mem_r[rec_wptr_r] <= rd_head_s;
    end
  end

  // Queue head/tail/count bookkeeping, allocator state, read port and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_NUB; i++) begin
        head_r[i] <= ADDR_ZERO_C;
        tail_r[i] <= ADDR_ZERO_C;
        cnt_r[i]  <= CNT_ZERO_C;
      end
      free_cnt_r     <= DEPTH_C;
      fresh_ptr_r    <= CNT_ZERO_C;
      rec_wptr_r     <= ADDR_ZERO_C;
      rec_rptr_r     <= ADDR_ZERO_C;
      rd_data_r      <= {DATA_WIDTH{1'b0}};
      rd_valid_r     <= 1'b0;
      err_wr_drop_r  <= 1'b0;
      err_rd_empty_r <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_NUB; i++) begin
        // A one-cell queue that is read and written together takes the new cell as head.
        if (wr_hit_s[i]) begin
          tail_r[i] <= alloc_addr_s;
          if ((cnt_r[i] == CNT_ZERO_C) || (rd_hit_s[i] && (cnt_r[i] == CNT_ONE_C))) begin
            head_r[i] <= alloc_addr_s;
          end else if (rd_hit_s[i]) begin
            head_r[i] <= next_mem_r[head_r[i]];
          end
        end else if (rd_hit_s[i]) begin
          head_r[i] <= next_mem_r[head_r[i]];
        end
        case ({wr_hit_s[i], rd_hit_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE_C;
          2'b01:   cnt_r[i] <= cnt_r[i] - CNT_ONE_C;
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   free_cnt_r <= free_cnt_r - CNT_ONE_C;
        2'b01:   free_cnt_r <= free_cnt_r + CNT_ONE_C;
        default: free_cnt_r <= free_cnt_r;
      endcase
      if (wr_acc_s && use_fresh_s) begin
        fresh_ptr_r <= fresh_ptr_r + CNT_ONE_C;
      end
      if (wr_acc_s && !use_fresh_s) begin
        rec_rptr_r <= ptr_inc(rec_rptr_r);
      end
      if (rd_acc_s) begin
        rec_wptr_r <= ptr_inc(rec_wptr_r);
        rd_data_r  <= data_mem_r[rd_head_s];
      end
      rd_valid_r     <= rd_acc_s;
      err_wr_drop_r  <= wr_en && !wr_ready_s;
      err_rd_empty_r <= rd_en && (cnt_r[rd_client] == CNT_ZERO_C);
    end
  end

  // Pack per-queue counts and empty flags onto the flat status ports.
  always_comb begin
    for (int i = 0; i < QUEUE_NUB; i++) begin
      q_count[i*CNT_W +: CNT_W] = cnt_r[i];
      q_empty[i]                = (cnt_r[i] == CNT_ZERO_C);
    end
  end

  assign wr_ready     = wr_ready_s;
  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;
  assign free_count   = free_cnt_r;
  assign err_wr_drop  = err_wr_drop_r;
  assign err_rd_empty = err_rd_empty_r;

endmodule

// File: tb/tb_voq_linked.sv
// Randomised + directed bench for voq_linked: per-queue reference queues feed a read-data
// scoreboard consumed by an independent monitor.
module tb_voq_linked;
  localparam int DW  = 128;
  localparam int DEP = 128;
  localparam int NQ  = 4;
  localparam int CW  = 8;
  localparam int LIM = DEP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_client = 2'd0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_client = 2'd0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [NQ-1:0] q_empty;
  logic [NQ*CW-1:0] q_count;
  logic [CW-1:0] free_count;
  logic          err_wr_drop, err_rd_empty;

  logic          l_rst = 1'b1;
  logic          l_wr_en = 1'b0;
  logic [1:0]    l_wr_client = 2'd0;
  logic [DW-1:0] l_wr_data = '0;
  logic          l_wr_ready;
  logic          l_rd_en = 1'b0;
  logic [1:0]    l_rd_client = 2'd0;
  logic [DW-1:0] l_rd_data;
  logic          l_rd_valid;
  logic [NQ-1:0] l_q_empty;
  logic [NQ*CW-1:0] l_q_count;
  logic [CW-1:0] l_free_count;
  logic          l_err_wr_drop, l_err_rd_empty;

  voq_linked dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_client(wr_client), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_client(rd_client), .rd_data(rd_data),
    .rd_valid(rd_valid), .q_empty(q_empty), .q_count(q_count), .free_count(free_count),
    .err_wr_drop(err_wr_drop), .err_rd_empty(err_rd_empty)
  );

  voq_linked #(.QUEUE_LIMIT(8)) dut_lim (
    .clk(clk), .rst(l_rst), .wr_en(l_wr_en), .wr_client(l_wr_client), .wr_data(l_wr_data),
    .wr_ready(l_wr_ready), .rd_en(l_rd_en), .rd_client(l_rd_client), .rd_data(l_rd_data),
    .rd_valid(l_rd_valid), .q_empty(l_q_empty), .q_count(l_q_count),
    .free_count(l_free_count), .err_wr_drop(l_err_wr_drop), .err_rd_empty(l_err_rd_empty)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mq [NQ][$];
  logic [DW-1:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int total_cells();
    int t = 0;
    for (int q = 0; q < NQ; q++) t += mq[q].size();
    return t;
  endfunction

  // One clock of stimulus on the main DUT, with model update and post-edge status checks.
  task automatic cycle(input bit r, input bit we, input int wc, input logic [DW-1:0] wd,
                       input bit re, input int rc);
    bit exp_ready, exp_rv, exp_drop, exp_rerr;
    int tot;
    @(negedge clk);
    rst = r; wr_en = we; wr_client = wc[1:0]; wr_data = wd; rd_en = re; rd_client = rc[1:0];
    #1;
    exp_ready = !r && (total_cells() < DEP) && (mq[wc].size() < LIM);
    check("wr_ready", {127'd0, wr_ready}, {127'd0, exp_ready});
    exp_drop = !r && we && !exp_ready;
    exp_rerr = !r && re && (mq[rc].size() == 0);
    exp_rv   = !r && re && (mq[rc].size() != 0);
    if (r) begin
      for (int q = 0; q < NQ; q++) mq[q].delete();
      exp_q.delete();
    end else begin
      if (exp_rv) exp_q.push_back(mq[rc].pop_front());
      if (we && exp_ready) mq[wc].push_back(wd);
    end
    @(posedge clk);
    #2;
    tot = total_cells();
    check("rd_valid", {127'd0, rd_valid}, {127'd0, exp_rv});
    check("err_wr_drop", {127'd0, err_wr_drop}, {127'd0, exp_drop});
    check("err_rd_empty", {127'd0, err_rd_empty}, {127'd0, exp_rerr});
    check("free_count", DW'(free_count), DW'(DEP - tot));
    for (int q = 0; q < NQ; q++) begin
      check("q_count", DW'(q_count[q*CW +: CW]), DW'(mq[q].size()));
      check("q_empty", {127'd0, q_empty[q]}, {127'd0, mq[q].size() == 0});
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Read-data monitor: every rd_valid must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    cycle(1'b1, 1'b0, 0, '0, 1'b0, 0);
    cycle(1'b1, 1'b1, 2, 128'hA1, 1'b1, 2);
    // Basic FIFO order on q2
    d = 128'hA1; cycle(1'b0, 1'b1, 2, d, 1'b0, 0);
    d = 128'hA2; cycle(1'b0, 1'b1, 2, d, 1'b0, 0);
    d = 128'hA3; cycle(1'b0, 1'b1, 2, d, 1'b0, 0);
    repeat (3) cycle(1'b0, 1'b0, 0, '0, 1'b1, 2);
    idle();
    // Interleaved queues, reads of q3 then q0
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, (i % 3 == 2) ? 3 : i % 3, rnd_data(), 1'b0, 0);
    repeat (3) cycle(1'b0, 1'b0, 0, '0, 1'b1, 3);
    repeat (3) cycle(1'b0, 1'b0, 0, '0, 1'b1, 0);
    repeat (3) cycle(1'b0, 1'b0, 0, '0, 1'b1, 1);
    cycle(1'b0, 1'b0, 0, '0, 1'b1, 3);
    // Fill all cells in q1, overflow, full with simultaneous read, then recycled write
    for (int i = 0; i < DEP; i++) cycle(1'b0, 1'b1, 1, DW'(32'h1000 + i), 1'b0, 0);
    cycle(1'b0, 1'b1, 1, 128'hDEAD, 1'b0, 0);
    cycle(1'b0, 1'b1, 1, 128'hBEEF, 1'b1, 1);
    cycle(1'b0, 1'b1, 1, 128'hC0DE, 1'b0, 0);
    cycle(1'b0, 1'b0, 0, '0, 1'b1, 1);
    cycle(1'b0, 1'b1, 2, 128'hF00D, 1'b0, 0);
    for (int i = 0; i < DEP; i++) cycle(1'b0, 1'b0, 0, '0, 1'b1, 1);
    // q2 holds one cell: simultaneous write and read of q2
    cycle(1'b0, 1'b1, 2, 128'h5151, 1'b1, 2);
    cycle(1'b0, 1'b0, 0, '0, 1'b1, 2);
    cycle(1'b0, 1'b0, 0, '0, 1'b1, 2);
    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 60), $urandom_range(0, 3),
            rnd_data(), ($urandom_range(0, 99) < 45), $urandom_range(0, 3));
    end
    // Reset mid-traffic
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, i % 4, rnd_data(), (i > 4), 0);
    cycle(1'b1, 1'b1, 0, rnd_data(), 1'b1, 1);
    idle();
    cycle(1'b0, 1'b0, 0, '0, 1'b1, 3);
    idle();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    // Per-queue cap on the QUEUE_LIMIT=8 instance
    @(negedge clk); l_rst = 1'b1;
    @(negedge clk); l_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      l_wr_en = 1'b1; l_wr_client = 2'd0; l_wr_data = DW'(i);
      #1;
      check("lim_ready_q0", {127'd0, l_wr_ready}, {127'd0, 1'b1});
      @(negedge clk);
    end
    l_wr_en = 1'b1; l_wr_client = 2'd0;
    #1;
    check("lim_full_q0", {127'd0, l_wr_ready}, {127'd0, 1'b0});
    @(negedge clk);
    check("lim_drop", {127'd0, l_err_wr_drop}, {127'd0, 1'b1});
    check("lim_cnt_q0", DW'(l_q_count[7:0]), DW'(8));
    l_wr_client = 2'd1;
    #1;
    check("lim_ready_q1", {127'd0, l_wr_ready}, {127'd0, 1'b1});
    @(negedge clk);
    l_wr_en = 1'b0;
    check("lim_cnt_q1", DW'(l_q_count[15:8]), DW'(1));
    check("lim_free", DW'(l_free_count), DW'(DEP - 9));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
